// File: rtl/tft_lcd_bus_driver.sv
// Avalon-MM slave that queues command/data/read requests and plays them out on an
// 8080-style 8-bit parallel LCD bus with programmable strobe low/high timing.
module tft_lcd_bus_driver #(
   parameter int         FIFO_DEPTH = 16,
   parameter int         FIFO_AW    = 4,
   parameter logic [3:0] LOW_DEF    = 4'd2,
   parameter logic [3:0] HIGH_DEF   = 4'd2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] address,
   input  logic       chipselect,
   input  logic       write_n,
   input  logic       read_n,
   input  logic [7:0] writedata,
   output logic [7:0] readdata,
   output logic       lcd_cs_n,
   output logic       lcd_rs,
   output logic       lcd_wr_n,
   output logic       lcd_rd_n,
   output logic [7:0] lcd_data_out,
   output logic       lcd_data_oe,
   input  logic [7:0] lcd_data_in
);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

   localparam logic [FIFO_AW:0] PTR_ONE = 1;

   state_t             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               pop;

   logic [9:0]         fifo_q [FIFO_DEPTH];
   logic [FIFO_AW:0]   wr_ptr_q, rd_ptr_q;
   logic [9:0]         cur_q;
   logic [3:0]         low_q, high_q;
   logic [7:0]         timing_q, rddata_q;
   logic               rd_valid_q, ovf_q;

   logic               empty, full, busy;
   logic               wr_en, rd_en, push_req, push_ok, sample;
   logic [9:0]         push_data;

   assign wr_en    = chipselect & ~write_n;
   assign rd_en    = chipselect & ~read_n;
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                     (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
   assign busy     = ~empty | (state_q != IDLE);
   assign push_req = wr_en & (address != 2'd2);
   assign push_ok  = push_req & ~full;
   // Read sample lands on the final STROBE clock of a read entry.
   assign sample   = (state_q == STROBE) && (cnt_q == low_q) && cur_q[9];

   always_comb begin
      case (address)
         2'd0:    push_data = {1'b0, 1'b1, writedata};
         2'd1:    push_data = {1'b0, 1'b0, writedata};
         default: push_data = {1'b1, 1'b1, 8'h00};
      endcase
   end

   always_comb begin
      case (address)
         2'd0:    readdata = {3'b000, ovf_q, rd_valid_q, busy, empty, full};
         2'd1:    readdata = 8'h00;
         2'd2:    readdata = timing_q;
         default: readdata = rddata_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push_ok) fifo_q[wr_ptr_q[FIFO_AW-1:0]] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cur_q      <= '0;
         low_q      <= '0;
         high_q     <= '0;
         timing_q   <= {HIGH_DEF, LOW_DEF};
         rddata_q   <= '0;
         rd_valid_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         // Timing is captured with the entry so later TIMING writes only affect later entries.
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
            cur_q    <= fifo_q[rd_ptr_q[FIFO_AW-1:0]];
            low_q    <= timing_q[3:0];
            high_q   <= timing_q[7:4];
         end
         if (wr_en && address == 2'd2) timing_q <= writedata;
         if (push_req && full)                ovf_q <= 1'b1;
         else if (rd_en && address == 2'd0)   ovf_q <= 1'b0;
         if (sample) begin
            rddata_q   <= lcd_data_in;
            rd_valid_q <= 1'b1;
         end else if (rd_en && address == 2'd3) begin
            rd_valid_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = SETUP;
            end
         end
         SETUP: begin
            state_d = STROBE;
            cnt_d   = '0;
         end
         STROBE: begin
            if (cnt_q == low_q) begin
               state_d = HOLD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: begin
            if (cnt_q == high_q) begin
               if (!empty) begin
                  pop     = 1'b1;
                  state_d = SETUP;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
      endcase
   end

   always_comb begin
      lcd_cs_n     = 1'b1;
      lcd_rs       = 1'b1;
      lcd_wr_n     = 1'b1;
      lcd_rd_n     = 1'b1;
      lcd_data_out = 8'h00;
      lcd_data_oe  = 1'b0;
      if (state_q != IDLE) begin
         lcd_cs_n     = 1'b0;
         lcd_rs       = cur_q[8];
         lcd_data_out = cur_q[7:0];
         lcd_data_oe  = ~cur_q[9];
         if (state_q == STROBE) begin
            lcd_wr_n = cur_q[9];
            lcd_rd_n = ~cur_q[9];
         end
      end
   end

endmodule

// File: tb/tb_tft_lcd_bus_driver.sv
// Directed bench for tft_lcd_bus_driver: register map, bus strobe timing, reads,
// FIFO overflow, reset abort and per-entry timing latch.
module tb_tft_lcd_bus_driver;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] address;
   logic       chipselect;
   logic       write_n;
   logic       read_n;
   logic [7:0] writedata;
   logic [7:0] readdata;
   logic       lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_data_oe;
   logic [7:0] lcd_data_out;
   logic [7:0] lcd_data_in;

   int n_cmp = 0;
   int n_bad = 0;

   tft_lcd_bus_driver dut (
      .clk          (clk),
      .reset        (reset),
      .address      (address),
      .chipselect   (chipselect),
      .write_n      (write_n),
      .read_n       (read_n),
      .writedata    (writedata),
      .readdata     (readdata),
      .lcd_cs_n     (lcd_cs_n),
      .lcd_rs       (lcd_rs),
      .lcd_wr_n     (lcd_wr_n),
      .lcd_rd_n     (lcd_rd_n),
      .lcd_data_out (lcd_data_out),
      .lcd_data_oe  (lcd_data_oe),
      .lcd_data_in  (lcd_data_in)
   );

   always #5 clk = ~clk;

   logic [12:0] bus;
   assign bus = {lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_data_oe, lcd_data_out};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   // Bus tasks are entered on a negedge and return on the following negedge.
   task automatic avwr(input logic [1:0] a, input logic [7:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic avrd(input string tag, input logic [1:0] a, input logic [7:0] want);
      address = a; chipselect = 1'b1; read_n = 1'b0;
      #1 chk(tag, readdata, want);
      @(negedge clk);
      chipselect = 1'b0; read_n = 1'b1;
   endtask

   task automatic cyc(input string tag, input logic cs, input logic rs, input logic wr,
                      input logic rd, input logic oe, input logic [7:0] d);
      chk(tag, bus, {cs, rs, wr, rd, oe, d});
      @(negedge clk);
   endtask

   initial begin
      int n;
      int lowcnt;
      logic prev_wr;

      reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
      writedata = '0; lcd_data_in = 8'h11;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // 1: reset state
      avrd("t1_status", 2'd0, 8'h02);
      avrd("t1_timing", 2'd2, 8'h22);
      chk("t1_bus_idle", bus, {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00});
      avrd("t1_addr1", 2'd1, 8'h00);

      // 2: command then data, back-to-back with cs_n held low
      avwr(2'd1, 8'h2C);
      avwr(2'd0, 8'hA5);
      cyc("t2_e1_setup", 0, 0, 1, 1, 1, 8'h2C);
      repeat (3) cyc("t2_e1_strobe", 0, 0, 0, 1, 1, 8'h2C);
      repeat (3) cyc("t2_e1_hold",   0, 0, 1, 1, 1, 8'h2C);
      cyc("t2_e2_setup", 0, 1, 1, 1, 1, 8'hA5);
      repeat (3) cyc("t2_e2_strobe", 0, 1, 0, 1, 1, 8'hA5);
      repeat (3) cyc("t2_e2_hold",   0, 1, 1, 1, 1, 8'hA5);
      cyc("t2_idle", 1, 1, 1, 1, 0, 8'h00);
      repeat (2) @(negedge clk);

      // 3: register read, sample taken on the last STROBE clock
      avwr(2'd3, 8'hFF);
      cyc("t3_queued_idle", 1, 1, 1, 1, 0, 8'h00);
      cyc("t3_setup", 0, 1, 1, 1, 0, 8'h00);
      repeat (2) cyc("t3_strobe", 0, 1, 1, 0, 0, 8'h00);
      lcd_data_in = 8'h93;
      cyc("t3_strobe_last", 0, 1, 1, 0, 0, 8'h00);
      lcd_data_in = 8'h77;
      repeat (3) cyc("t3_hold", 0, 1, 1, 1, 0, 8'h00);
      cyc("t3_idle", 1, 1, 1, 1, 0, 8'h00);
      avrd("t3_status_valid", 2'd0, 8'h0A);
      avrd("t3_rddata", 2'd3, 8'h93);
      avrd("t3_status_clr", 2'd0, 8'h02);

      // 4: overflow while a slow dummy entry occupies the bus
      avwr(2'd2, 8'hFF);
      avwr(2'd1, 8'hEE);
      for (int i = 0; i < 17; i++) avwr(2'd0, 8'(8'h40 + i));
      avrd("t4_status_ovf", 2'd0, 8'h15);
      avrd("t4_status_ovf_clr", 2'd0, 8'h05);
      n = 0;
      prev_wr = lcd_wr_n;
      for (int c = 0; c < 700 && n < 16; c++) begin
         @(negedge clk);
         if (!lcd_wr_n && prev_wr) begin
            chk("t4_byte", {lcd_rs, lcd_data_out}, {1'b1, 8'(8'h40 + n)});
            n++;
         end
         prev_wr = lcd_wr_n;
      end
      chk("t4_count", n, 16);
      repeat (40) @(negedge clk);
      avrd("t4_status_done", 2'd0, 8'h02);

      // 5: reset during STROBE aborts the bus cycle and flushes the queue
      avwr(2'd2, 8'h31);
      avwr(2'd0, 8'hAA);
      avwr(2'd0, 8'hBB);
      avwr(2'd0, 8'hCC);
      chk("t5_in_strobe", lcd_wr_n, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      chk("t5_bus_idle", bus, {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00});
      avrd("t5_status", 2'd0, 8'h02);
      avrd("t5_timing", 2'd2, 8'h22);
      reset = 1'b0;
      lowcnt = 0;
      for (int c = 0; c < 20; c++) begin
         if (!lcd_cs_n) lowcnt++;
         @(negedge clk);
      end
      chk("t5_no_cs", lowcnt, 0);

      // 6: TIMING rewrite mid-transfer only affects the next entry
      avwr(2'd0, 8'h11);
      avwr(2'd0, 8'h22);
      avwr(2'd2, 8'h00);
      repeat (3) cyc("t6_e1_strobe", 0, 1, 0, 1, 1, 8'h11);
      repeat (3) cyc("t6_e1_hold",   0, 1, 1, 1, 1, 8'h11);
      cyc("t6_e2_setup",  0, 1, 1, 1, 1, 8'h22);
      cyc("t6_e2_strobe", 0, 1, 0, 1, 1, 8'h22);
      cyc("t6_e2_hold",   0, 1, 1, 1, 1, 8'h22);
      cyc("t6_idle",      1, 1, 1, 1, 0, 8'h00);
      avrd("t6_timing", 2'd2, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
